// File: rtl/alu_seq_nb.sv
// alu_seq_nb: registered N-bit sequential ALU with an accumulator and status flags.
// Most operations finish in one accept cycle. MUL runs a WIDTH-step shift-add
// loop in the BUSY state. During that loop the ALU refuses new requests.
module alu_seq_nb #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCB_in,
  input  logic [3:0]       iMode,
  input  logic             iUseAcc,
  output logic [WIDTH-1:0] oResult,
  output logic [WIDTH-1:0] oResultHi,
  output logic             oCB_out,
  output logic             oZero,
  output logic             oNeg,
  output logic             oOvf,
  output logic             oValid
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_DEC  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_LOAD = 4'b1100;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] resultHi_q;
  logic             cb_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic             valid_q;

  logic [WIDTH-1:0] mulA_q;
  logic [WIDTH-1:0] prodHi_q;
  logic [WIDTH-1:0] prodLo_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             isMul;
  logic             isCmp;
  logic             isReserved;
  logic             lastStep;

  logic [WIDTH-1:0] opA;
  logic [WIDTH:0]   cinExt;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;
  logic [WIDTH:0]   incExt;
  logic [WIDTH:0]   decExt;
  logic [WIDTH-1:0] opRes;
  logic             opCb;
  logic             opOvf;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;

  // A request is taken only in IDLE. A request on a reset edge is dropped.
  always_comb begin
    accept     = iValid && (state_q == IDLE) && !iRst;
    isMul      = (iMode == OP_MUL);
    isCmp      = (iMode == OP_CMP);
    isReserved = (iMode > OP_LOAD);
    lastStep   = (cnt_q == CW'(WIDTH - 1));
  end

  // Single-cycle operation results, computed from the operands being accepted.
  always_comb begin
    opA     = iUseAcc ? acc_q : iA;
    cinExt  = {{WIDTH{1'b0}}, iCB_in};
    sumExt  = {1'b0, opA} + {1'b0, iB} + cinExt;
    diffExt = {1'b0, opA} - {1'b0, iB} - cinExt;
    incExt  = {1'b0, opA} + {{WIDTH{1'b0}}, 1'b1};
    decExt  = {1'b0, opA} - {{WIDTH{1'b0}}, 1'b1};
    opRes   = '0;
    opCb    = 1'b0;
    opOvf   = 1'b0;
    case (iMode)
      OP_ADD: begin
        opRes = sumExt[WIDTH-1:0];
        opCb  = sumExt[WIDTH];
        opOvf = (opA[MSB] == iB[MSB]) && (sumExt[MSB] != opA[MSB]);
      end
      OP_SUB, OP_CMP: begin
        opRes = diffExt[WIDTH-1:0];
        opCb  = diffExt[WIDTH];
        opOvf = (opA[MSB] != iB[MSB]) && (diffExt[MSB] != opA[MSB]);
      end
      OP_AND: opRes = opA & iB;
      OP_OR:  opRes = opA | iB;
      OP_XOR: opRes = opA ^ iB;
      OP_NOT: opRes = ~opA;
      OP_INC: begin
        opRes = incExt[WIDTH-1:0];
        opCb  = incExt[WIDTH];
        opOvf = !opA[MSB] && incExt[MSB];
      end
      OP_DEC: begin
        opRes = decExt[WIDTH-1:0];
        opCb  = decExt[WIDTH];
        opOvf = opA[MSB] && !decExt[MSB];
      end
      OP_SHL: begin
        opRes = {opA[WIDTH-2:0], iCB_in};
        opCb  = opA[MSB];
      end
      OP_SHR: begin
        opRes = {iCB_in, opA[WIDTH-1:1]};
        opCb  = opA[0];
      end
      OP_LOAD: opRes = iB;
      default: begin
        opRes = '0;
        opCb  = 1'b0;
        opOvf = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step. If the multiplier LSB is set, add the
  // multiplicand into the high half, then shift the whole product right.
  always_comb begin
    mulSum = {1'b0, prodHi_q} + (prodLo_q[0] ? {1'b0, mulA_q} : '0);
    stepHi = mulSum[WIDTH:1];
    stepLo = {mulSum[0], prodLo_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Only MUL leaves IDLE. BUSY ends after the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && isMul) state_d = BUSY;
      BUSY:    if (lastStep)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready output. Reset forces ready high even when a multiply is in flight.
  always_comb begin
    oReady = (state_q == IDLE) || iRst;
  end

  // Datapath registers: outputs, flags, accumulator and multiply working state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_q      <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      cb_q       <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      mulA_q     <= '0;
      prodHi_q   <= '0;
      prodLo_q   <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        if (isMul) begin
          mulA_q   <= opA;
          prodHi_q <= '0;
          prodLo_q <= iB;
          cnt_q    <= '0;
        end else if (isReserved) begin
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b1;
          cb_q    <= opCb;
          zero_q  <= (opRes == '0);
          neg_q   <= opRes[MSB];
          ovf_q   <= opOvf;
          if (!isCmp) begin
            result_q   <= opRes;
            resultHi_q <= '0;
            acc_q      <= opRes;
          end
        end
      end else if (state_q == BUSY) begin
        prodHi_q <= stepHi;
        prodLo_q <= stepLo;
        cnt_q    <= cnt_q + CW'(1);
        if (lastStep) begin
          valid_q    <= 1'b1;
          result_q   <= stepLo;
          resultHi_q <= stepHi;
          acc_q      <= stepLo;
          cb_q       <= (stepHi != '0);
          zero_q     <= ({stepHi, stepLo} == '0);
          neg_q      <= stepHi[MSB];
          ovf_q      <= 1'b0;
        end
      end
    end
  end

  // Drive the output ports from the registers.
  always_comb begin
    oResult   = result_q;
    oResultHi = resultHi_q;
    oCB_out   = cb_q;
    oZero     = zero_q;
    oNeg      = neg_q;
    oOvf      = ovf_q;
    oValid    = valid_q;
  end

endmodule

// File: tb/tb_alu_seq_nb.sv
// tb_alu_seq_nb: directed scenarios and random operations for alu_seq_nb.
// Each output is checked against an integer-arithmetic reference model.
module tb_alu_seq_nb;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;
   localparam int MAXS = (1 << (W - 1)) - 1;
   localparam int MINS = -(1 << (W - 1));

   logic         iClk = 1'b0;
   logic         iRst;
   logic         iValid;
   logic         oReady;
   logic [W-1:0] iA;
   logic [W-1:0] iB;
   logic         iCB_in;
   logic [3:0]   iMode;
   logic         iUseAcc;
   logic [W-1:0] oResult;
   logic [W-1:0] oResultHi;
   logic         oCB_out;
   logic         oZero;
   logic         oNeg;
   logic         oOvf;
   logic         oValid;

   int checks = 0;
   int errors = 0;

   int mAcc, mRes, mHi, mCb, mZ, mN, mO;
   int expValid, expReady;

   alu_seq_nb #(.WIDTH(W)) dut (
      .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
      .iA(iA), .iB(iB), .iCB_in(iCB_in), .iMode(iMode), .iUseAcc(iUseAcc),
      .oResult(oResult), .oResultHi(oResultHi), .oCB_out(oCB_out),
      .oZero(oZero), .oNeg(oNeg), .oOvf(oOvf), .oValid(oValid)
   );

   // Free-running clock with a 10-unit period.
   always #5 iClk = ~iClk;

   // Stop a runaway simulation.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int toSigned(input int v);
      return (v > MAXS) ? v - (1 << W) : v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, ".result"}, 32'(oResult),   mRes);
      checkOutput({tag, ".hi"},     32'(oResultHi), mHi);
      checkOutput({tag, ".cb"},     32'(oCB_out),   mCb);
      checkOutput({tag, ".zero"},   32'(oZero),     mZ);
      checkOutput({tag, ".neg"},    32'(oNeg),      mN);
      checkOutput({tag, ".ovf"},    32'(oOvf),      mO);
      checkOutput({tag, ".valid"},  32'(oValid),    expValid);
      checkOutput({tag, ".ready"},  32'(oReady),    expReady);
   endtask

   function automatic void modelReset();
      mAcc = 0; mRes = 0; mHi = 0; mCb = 0; mZ = 0; mN = 0; mO = 0;
   endfunction

   // Reference model: applies one completed operation to the expected state.
   function automatic void modelApply(input int mode, input int a, input int b, input int cin, input bit useAcc);
      int opA, full, s, r, cb, ovf, p;
      opA = useAcc ? mAcc : a;
      r = 0; cb = 0; ovf = 0;
      case (mode)
         0: begin full = opA + b + cin; r = full & MASK; cb = int'(full > MASK);
                  s = toSigned(opA) + toSigned(b) + cin; ovf = int'(s > MAXS || s < MINS); end
         1: begin full = opA - b - cin; r = full & MASK; cb = int'(full < 0);
                  s = toSigned(opA) - toSigned(b) - cin; ovf = int'(s > MAXS || s < MINS); end
         2: r = opA & b;
         3: r = opA | b;
         4: r = opA ^ b;
         5: r = (~opA) & MASK;
         6: begin full = opA + 1; r = full & MASK; cb = int'(full > MASK);
                  s = toSigned(opA) + 1; ovf = int'(s > MAXS); end
         7: begin full = opA - 1; r = full & MASK; cb = int'(full < 0);
                  s = toSigned(opA) - 1; ovf = int'(s < MINS); end
         8: begin r = ((opA << 1) | cin) & MASK; cb = (opA >> (W - 1)) & 1; end
         9: begin r = (opA >> 1) | (cin << (W - 1)); cb = opA & 1; end
         10: begin
            p = opA * b;
            mRes = p & MASK; mHi = p >> W; mAcc = mRes;
            mCb = int'(mHi != 0); mZ = int'(p == 0); mN = (mHi >> (W - 1)) & 1; mO = 0;
            return;
         end
         11: begin
            full = opA - b - cin;
            s = toSigned(opA) - toSigned(b) - cin;
            mCb = int'(full < 0); mZ = int'((full & MASK) == 0);
            mN = ((full & MASK) >> (W - 1)) & 1; mO = int'(s > MAXS || s < MINS);
            return;
         end
         12: r = b;
         default: return;
      endcase
      mRes = r; mHi = 0; mAcc = r; mCb = cb; mO = ovf;
      mZ = int'(r == 0); mN = (r >> (W - 1)) & 1;
   endfunction

   task automatic driveInputs(input int mode, input int a, input int b, input int cin, input bit useAcc);
      iValid  = 1'b1;
      iMode   = 4'(mode);
      iA      = W'(a);
      iB      = W'(b);
      iCB_in  = cin[0];
      iUseAcc = useAcc;
   endtask

   // Single-cycle request: accepted at the next edge, results checked just after it.
   task automatic applyStimulus(input string tag, input int mode, input int a, input int b, input int cin, input bit useAcc);
      driveInputs(mode, a, b, cin, useAcc);
      @(posedge iClk); #1;
      modelApply(mode, a, b, cin, useAcc);
      expValid = 1; expReady = 1;
      compareAll(tag);
   endtask

   task automatic idleCycle(input string tag);
      iValid = 1'b0;
      @(posedge iClk); #1;
      expValid = 0; expReady = 1;
      compareAll(tag);
   endtask

   // MUL with an ADD request held on iValid during the busy phase. Operand
   // inputs are scrambled after accept.
   task automatic mulOp(input string tag, input int a, input int b, input bit useAcc);
      driveInputs(10, a, b, 0, useAcc);
      @(posedge iClk); #1;
      expValid = 0; expReady = 0;
      compareAll({tag, ".accept"});
      for (int i = 1; i <= W; i++) begin
         driveInputs(0, $urandom_range(0, MASK), $urandom_range(0, MASK), 1, 1'($urandom_range(0, 1)));
         @(posedge iClk); #1;
         if (i == W) begin
            modelApply(10, a, b, 0, useAcc);
            expValid = 1; expReady = 1;
            compareAll({tag, ".done"});
         end else begin
            expValid = 0; expReady = 0;
            compareAll({tag, ".busy"});
         end
      end
      iValid = 1'b0;
   endtask

   task automatic applyReset(input string tag);
      iRst = 1'b1;
      driveInputs(0, 5, 5, 1, 0);
      #1;
      checkOutput({tag, ".readyInReset"}, 32'(oReady), 1);
      @(posedge iClk); #1;
      @(posedge iClk); #1;
      modelReset();
      expValid = 0; expReady = 1;
      compareAll(tag);
      iRst = 1'b0;
      iValid = 1'b0;
   endtask

   task automatic mulAbort(input string tag, input int a, input int b);
      driveInputs(10, a, b, 0, 0);
      @(posedge iClk); #1;
      expValid = 0; expReady = 0;
      compareAll({tag, ".accept"});
      iValid = 1'b0;
      @(posedge iClk); #1;
      compareAll({tag, ".busy1"});
      iRst = 1'b1;
      #1;
      checkOutput({tag, ".readyInReset"}, 32'(oReady), 1);
      @(posedge iClk); #1;
      modelReset();
      expValid = 0; expReady = 1;
      compareAll({tag, ".reset"});
      iRst = 1'b0;
      @(posedge iClk); #1;
      compareAll({tag, ".after"});
   endtask

   // Main sequence: directed scenarios first, then random operations.
   initial begin
      int mode;
      iRst = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iCB_in = 1'b0; iMode = '0; iUseAcc = 1'b0;
      modelReset();
      applyReset("reset");

      applyStimulus("add15p1c1", 0, 15, 1, 1, 0);
      idleCycle("add.pulseEnd");

      applyStimulus("sub0m1c1", 1, 0, 1, 1, 0);
      applyStimulus("cmp5v5", 11, 5, 5, 0, 0);
      idleCycle("cmp.idle");

      applyStimulus("load3", 12, 0, 3, 0, 0);
      applyStimulus("accAdd1", 0, 0, 4, 0, 1);
      applyStimulus("accAdd2", 0, 0, 4, 0, 1);
      applyStimulus("accAdd3", 0, 0, 4, 0, 1);
      idleCycle("accAdd.idle");

      mulOp("mul13x11", 13, 11, 0);
      idleCycle("mul.idle");

      mulAbort("mulAbort", 7, 9);
      applyStimulus("inc15", 6, 15, 0, 0, 0);
      idleCycle("inc.idle");

      applyStimulus("shl9c1", 8, 9, 0, 1, 0);
      applyStimulus("shr9c0", 9, 9, 0, 0, 0);
      applyStimulus("reserved14", 14, 3, 7, 1, 0);
      idleCycle("reserved.idle");

      for (int n = 0; n < 300; n++) begin
         mode = $urandom_range(0, 15);
         if ($urandom_range(0, 49) == 0) begin
            applyReset("rndReset");
         end else if (mode == 10) begin
            mulOp("rndMul", $urandom_range(0, MASK), $urandom_range(0, MASK), 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus("rndOp", mode, $urandom_range(0, MASK), $urandom_range(0, MASK),
                          $urandom_range(0, 1), 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 1) == 1) idleCycle("rndIdle");
      end
      idleCycle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_nb.md
# alu_seq_nb

Registered, parametrised N-bit sequential ALU with an internal accumulator, status flags, and a valid/ready request handshake. It keeps the eight single-cycle operations of the combinational N-bit ALU with the same encodings. It adds shift-through-carry, compare, load, and an iterative unsigned multiply that takes WIDTH cycles. It sits between the datapath register file and the result bus and is the ALU core for the upcoming multi-cycle datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- iClk  in  1  clock, all state updates on rising edge
- iRst  in  1  synchronous, active-high reset
- iValid  in  1  operation request
- oReady  out  1  high when an operation can be accepted
- iA  in  WIDTH  operand A
- iB  in  WIDTH  operand B
- iCB_in  in  1  carry/borrow/shift-in bit
- iMode  in  4  operation select
- iUseAcc  in  1  when 1, operand A is the internal accumulator instead of iA
- oResult  out  WIDTH  registered result (low half for MUL)
- oResultHi  out  WIDTH  high half of MUL product; 0 after any other op
- oCB_out  out  1  carry/borrow/shifted-out bit
- oZero, oNeg, oOvf  out  1 each  zero, negative (MSB), signed-overflow flags
- oValid  out  1  one-cycle pulse: outputs were updated by a completed op

## Operation
- Accept happens on a rising edge with iValid=1 and oReady=1. Operands, iCB_in, iMode and iUseAcc are latched at accept. Later input changes have no effect on the op in progress.
- Opcodes and results. A is the selected operand A. All arithmetic is modulo 2^WIDTH.
  - 0000 ADD: A+B+cin; CB = carry.
  - 0001 SUB: A−B−cin; CB = borrow.
  - 0010 AND, 0011 OR, 0100 XOR: CB=0.
  - 0101 NOT A: CB=0.
  - 0110 INC: A+1; CB = carry.
  - 0111 DEC: A−1; CB = borrow.
  - 1000 SHL: {A[W-2:0],cin}; CB = A[W-1].
  - 1001 SHR: {cin,A[W-1:1]}; CB = A[0].
  - 1010 MUL: unsigned A×B, 2·WIDTH-bit product. oResultHi:oResult = product. CB = (product high half ≠ 0).
  - 1011 CMP: computes A−B−cin for flags and CB only. oResult, oResultHi and the accumulator are unchanged.
  - 1100 LOAD: result = B; CB=0.
  - 1101–1111 reserved: accepted, oValid pulses, all outputs and the accumulator held.
- oResultHi is 0 after every op except MUL and CMP; CMP holds it.
- Flags:
  - oZero: result == 0. For MUL, the full product == 0. For CMP, the difference == 0.
  - oNeg: MSB of the result. For MUL, MSB of oResultHi. For CMP, MSB of the difference.
  - oOvf: two's-complement overflow for ADD, SUB, CMP, INC, DEC; 0 for all other ops.
- Accumulator: WIDTH bits, loaded with oResult's new value by every op except CMP and reserved opcodes.
- FSM:
  - IDLE: oReady=1. A MUL accept moves to BUSY and clears the iteration counter. All other ops complete in IDLE.
  - BUSY: oReady=0. Performs one shift-add step per cycle. After WIDTH steps, writes outputs, pulses oValid and returns to IDLE.
- iValid while BUSY is ignored; no queueing.

## Timing
- Reset (iRst=1 at an edge):
  - State → IDLE; counter, accumulator, oResult, oResultHi, oCB_out and all flags → 0; oValid → 0.
  - oReady is 1 during and after reset. Requests on an edge with iRst=1 are ignored.
  - Reset mid-MUL aborts the op with no oValid.
- Single-cycle ops:
  - Accepted at edge k; outputs and oValid visible after edge k. Latency is 1 edge.
  - oValid drops after edge k+1 unless another op is accepted at edge k+1.
  - Back-to-back accepts sustain a throughput of 1 op per cycle.
  - iUseAcc on back-to-back ops sees the accumulator value written at the previous edge.
- MUL:
  - Accepted at edge k; oReady=0 after edges k … k+WIDTH−1.
  - Result and oValid appear after edge k+WIDTH, with oReady=1 in the same cycle.
  - Next accept is possible at edge k+WIDTH+1.
- Outputs are held between ops. oValid is never high for two consecutive cycles without two accepts.

## Test plan
- Reset, then ADD iA=15 iB=1 cin=1 → oResult=0001, oCB_out=1, oZero=0, oOvf=0; oValid high for exactly 1 cycle after the accept edge.
- SUB iA=0 iB=1 cin=1 → 1110, CB=1, oNeg=1. Then CMP iA=5 iB=5 cin=0 → oZero=1, CB=0, oResult still 1110.
- LOAD iB=3, then three back-to-back ADD with iUseAcc=1, iB=4 → results 0111, 1011 (oOvf=1 on the second), 1111. oValid stays high for all 4 consecutive cycles.
- MUL iA=13 iB=11 → oResultHi=1000, oResult=1111, CB=1, after exactly 4 busy cycles. An ADD request with iValid held high during busy is ignored; oReady returns with oValid.
- Start MUL, assert iRst on the 2nd busy cycle → all outputs 0, no oValid, oReady=1. Then INC iA=1111 → 0000, CB=1, oZero=1.
- SHL iA=1001 cin=1 → 0011, CB=1. SHR iA=1001 cin=0 → 0100, CB=1. Reserved 1110 → oValid pulse, outputs unchanged.
